// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
//   DEF_DATA_W / DEF_DEPTH / DEF_NUM_READ : default geometry
//   slice_lo()                            : low bit of port i in a packed port vector
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_DEPTH    = 32;
  localparam int unsigned DEF_NUM_READ = 2;

  // Packed multi-port buses place port i at [i*width +: width].
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Bus between decode/issue + writeback stages and the register file.
//   master : pipeline side (drives addresses, write data, reserve)
//   slave  : register file side (drives read data, busy flags, conflict, busy_count)
interface multiport_register_file_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_READ = 2
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [NUM_READ*ADDR_W-1:0] read_address;
  logic [NUM_READ*DATA_W-1:0] read_data;
  logic [NUM_READ-1:0]        read_busy;
  logic [ADDR_W-1:0]          write_address;
  logic [DATA_W-1:0]          write_data;
  logic                       write_enable;
  logic [ADDR_W-1:0]          reserve_address;
  logic                       reserve_enable;
  logic                       reserve_conflict;
  logic [ADDR_W:0]            busy_count;

  modport master (
    output read_address, write_address, write_data, write_enable,
           reserve_address, reserve_enable,
    input  read_data, read_busy, reserve_conflict, busy_count
  );

  modport slave (
    input  read_address, write_address, write_data, write_enable,
           reserve_address, reserve_enable,
    output read_data, read_busy, reserve_conflict, busy_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with occupancy counter and WAW conflict detect.
//   reserve_enable/reserve_address : mark destination busy (issue)
//   release_enable/release_address : clear busy (writeback)
//   busy                           : registered busy vector
//   busy_count                     : registered number of busy registers
//   reserve_conflict               : reserve hits a busy register not released this cycle
module regfile_scoreboard #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_address,
  input  logic              release_enable,
  input  logic [ADDR_W-1:0] release_address,
  output logic [DEPTH-1:0]  busy,
  output logic [CNT_W-1:0]  busy_count,
  output logic              reserve_conflict
);

  logic             set_ok;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_next;
  logic [CNT_W-1:0] count_next;

  // Next busy vector and count; reserve is applied after release so it wins.
  always_comb begin
    set_ok     = reserve_enable && !((ZERO_REG != 0) && (reserve_address == '0));
    inc        = set_ok && !busy[reserve_address];
    dec        = release_enable && busy[release_address] &&
                 !(set_ok && (reserve_address == release_address));
    busy_next  = busy;
    if (release_enable) busy_next[release_address] = 1'b0;
    if (set_ok)         busy_next[reserve_address] = 1'b1;
    count_next = busy_count + CNT_W'(inc) - CNT_W'(dec);
    reserve_conflict = reserve_enable && busy[reserve_address] &&
                       !(release_enable && (release_address == reserve_address));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Register file: one synchronous write port, NUM_READ combinational read ports,
// optional hardwired-zero r0, optional write-to-read bypass, busy scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of multiport_register_file_if
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_READ = DEF_NUM_READ,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multiport_register_file_if.slave    bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              write_ok;

  // Writes to r0 are dropped when it is hardwired to zero.
  assign write_ok = bus.write_enable &&
                    !((ZERO_REG != 0) && (bus.write_address == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (write_ok) begin
      regs[bus.write_address] <= bus.write_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk              (clk),
    .rst_n            (rst_n),
    .reserve_enable   (bus.reserve_enable),
    .reserve_address  (bus.reserve_address),
    .release_enable   (bus.write_enable),
    .release_address  (bus.write_address),
    .busy             (busy),
    .busy_count       (bus.busy_count),
    .reserve_conflict (bus.reserve_conflict)
  );

  // Per-port read mux: zero register, then forwarded write, then storage.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
    localparam int unsigned A_LO = slice_lo(gi, ADDR_W);
    localparam int unsigned D_LO = slice_lo(gi, DATA_W);

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;
    logic              hit_zero;
    logic              hit_wr;

    assign ra = bus.read_address[A_LO +: ADDR_W];

    always_comb begin
      hit_zero = (ZERO_REG != 0) && (ra == '0);
      hit_wr   = (BYPASS != 0) && bus.write_enable && (bus.write_address == ra);
      rd       = regs[ra];
      rb       = busy[ra];
      if (hit_zero) begin
        rd = '0;
        rb = 1'b0;
      end else if (hit_wr) begin
        // Forwarded data is valid now, so the register no longer looks busy.
        rd = bus.write_data;
        rb = 1'b0;
      end
    end

    assign bus.read_data[D_LO +: DATA_W] = rd;
    assign bus.read_busy[gi]             = rb;
  end

endmodule
